// File: rtl/vedic_8x8.sv
// vedic_8x8: unsigned 8x8 Urdhva-Tiryagbhyam multiplier with 16-bit product and >8-bit flag.
// Latency: 3 clocks (operand regs, 4x4 partial products, final combine); one result per clock.
// Backpressure: none, always streaming; a new operand pair is accepted every clock.
module vedic_8x8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod,
  output logic        overflow
);

  // 2x2 cell: bit products and two half adders.
  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic c1, c2, c3, s1, h1;
    c1 = x[1] & y[0];
    c2 = x[0] & y[1];
    c3 = x[1] & y[1];
    s1 = c1 ^ c2;
    h1 = c1 & c2;
    return {c3 & h1, c3 ^ h1, s1, x[0] & y[0]};
  endfunction

  // 4x4 block: same vertical-crosswise structure as the 8x8 level, built from 2x2 cells.
  function automatic logic [7:0] vedic_4x4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q_ll, q_hl, q_lh, q_hh;
    logic [4:0] mid;
    q_ll = vedic_2x2(x[1:0], y[1:0]);
    q_hl = vedic_2x2(x[3:2], y[1:0]);
    q_lh = vedic_2x2(x[1:0], y[3:2]);
    q_hh = vedic_2x2(x[3:2], y[3:2]);
    mid  = {1'b0, q_hl} + {1'b0, q_lh};
    return {4'b0, q_ll} + {1'b0, mid, 2'b0} + {q_hh, 4'b0};
  endfunction

  logic [7:0]  a_q, b_q;
  logic [7:0]  pp_ll, pp_hl, pp_lh, pp_hh;
  logic [7:0]  pp_ll_d, pp_hl_d, pp_lh_d, pp_hh_d;
  logic [8:0]  mid_sum;
  logic [15:0] prod_d;

  always_comb begin
    pp_ll_d = vedic_4x4(a_q[3:0], b_q[3:0]);
    pp_hl_d = vedic_4x4(a_q[7:4], b_q[3:0]);
    pp_lh_d = vedic_4x4(a_q[3:0], b_q[7:4]);
    pp_hh_d = vedic_4x4(a_q[7:4], b_q[7:4]);
  end

  // Middle term kept at 9 bits so the cross-product carry is never lost.
  always_comb begin
    mid_sum = {1'b0, pp_hl} + {1'b0, pp_lh};
    prod_d  = {8'b0, pp_ll} + {3'b0, mid_sum, 4'b0} + {pp_hh, 8'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      pp_ll    <= '0;
      pp_hl    <= '0;
      pp_lh    <= '0;
      pp_hh    <= '0;
      prod     <= '0;
      overflow <= 1'b0;
    end else begin
      a_q      <= a;
      b_q      <= b;
      pp_ll    <= pp_ll_d;
      pp_hl    <= pp_hl_d;
      pp_lh    <= pp_lh_d;
      pp_hh    <= pp_hh_d;
      prod     <= prod_d;
      overflow <= |prod_d[15:8];
    end
  end

endmodule

// File: tb/tb_vedic_8x8.sv
// Bench for vedic_8x8: randomized and directed operands against a plain a*b reference delayed 3 clocks.
module tb_vedic_8x8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a, b;
  logic [15:0] prod;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  vedic_8x8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .prod(prod),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied at a negedge are due on the outputs three negedges later.
  task automatic drive(input int x, input int y);
    a = 8'(x);
    b = 8'(y);
    exp_q.push_back(x * y);
  endtask

  task automatic test_reset();
    int e;
    a = 8'd255;
    b = 8'd255;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (prod !== 16'd0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: prod=%0d ovf=%0b, expected prod=0 ovf=0", prod, overflow);
      end
    end
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      e = (cyc == 3) ? 65025 : 0;
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL reset_release cyc%0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 cyc, prod, overflow, e, (e > 255));
      end
    end
    exp_q.delete();
    repeat (3) exp_q.push_back(65025);
  endtask

  task automatic test_stream();
    int sa[5] = '{15, 25, 50, 100, 255};
    int sb[5] = '{3, 10, 50, 200, 255};
    int e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL stream %0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 i, prod, overflow, e, (e > 255));
      end
      drive(sa[i], sb[i]);
    end
  endtask

  task automatic test_edges();
    int ea[5] = '{1, 0, 128, 16, 15};
    int eb[5] = '{255, 255, 128, 16, 17};
    int e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL edges %0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 i, prod, overflow, e, (e > 255));
      end
      drive(ea[i], eb[i]);
    end
  endtask

  task automatic test_random();
    int e;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL random %0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 i, prod, overflow, e, (e > 255));
      end
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_midstream_reset();
    int xa[4] = '{200, 3, 7, 13};
    int xb[4] = '{200, 5, 11, 17};
    int ya[6] = '{9, 2, 30, 1, 16, 0};
    int yb[6] = '{9, 100, 30, 1, 16, 0};
    int e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL mid_fill %0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 i, prod, overflow, e, (e > 255));
      end
      drive(xa[i], xb[i]);
    end
    // 40000 is on the outputs with 15 and 77 queued behind it.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (prod !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: prod=%0d ovf=%0b, expected prod=0 ovf=0", prod, overflow);
    end
    @(negedge clk);
    checks++;
    if (prod !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: prod=%0d ovf=%0b, expected prod=0 ovf=0", prod, overflow);
    end
    exp_q.delete();
    rst_n = 1'b1;
    drive(ya[0], yb[0]);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      e = (exp_q.size() >= 3) ? exp_q.pop_front() : 0;
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL mid_release %0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 i, prod, overflow, e, (e > 255));
      end
      drive(ya[i], yb[i]);
    end
  endtask

  task automatic test_exhaustive();
    int e;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (prod !== 16'(e) || overflow !== (e > 255)) begin
          errors++;
          $display("FAIL exhaustive a=%0d b=%0d: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                   x, y, prod, overflow, e, (e > 255));
        end
        drive(x, y);
      end
    end
    repeat (3) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (prod !== 16'(e) || overflow !== (e > 255)) begin
        errors++;
        $display("FAIL exhaustive_drain: prod=%0d ovf=%0b, expected prod=%0d ovf=%0b",
                 prod, overflow, e, (e > 255));
      end
      drive(0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_edges();
    test_random();
    test_midstream_reset();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vedic_8x8.md
Name: vedic_8x8

Overview:
Pipelined unsigned 8x8 multiplier using the Vedic Urdhva-Tiryagbhyam (vertical-crosswise) decomposition: 2x2 base cells build 4x4 blocks, and four 4x4 blocks build the 8x8 result. It accepts a new operand pair every clock and produces a full 16-bit product plus an "exceeds 8 bits" flag after a fixed latency. It is a datapath leaf block with no handshake and is always streaming.

Parameters:
None. Width is fixed at 8x8 and the pipeline depth is fixed at 3 register stages.

Ports:
clk       input   1   rising-edge clock
rst_n     input   1   asynchronous active-low reset
a         input   8   multiplicand, unsigned
b         input   8   multiplier, unsigned
prod      output  16  registered product a*b, unsigned
overflow  output  1   registered flag: 1 when the product does not fit in 8 bits (prod[15:8] != 0)

Behaviour:
- Reset: rst_n low asynchronously clears every pipeline register, with prod=16'd0 and overflow=0. Outputs stay 0 while rst_n is low. The first valid result appears 3 rising edges after release, once operands are being sampled.
- Stage 1 (edge k): register a and b.
- Stage 2 (edge k+1): compute the four 4x4 Vedic partial products from the registered operands and register them (8 bits each):
  - AL*BL
  - AH*BL
  - AL*BH
  - AH*BH
- Stage 3 (edge k+2): combine the partial products and register prod and overflow.
  - Combination: prod = PP_LL + ((PP_HL + PP_LH) << 4) + (PP_HH << 8).
  - The middle sum is carried at 9 bits. The final sum is 16 bits exactly.
- Latency: operands sampled at edge k appear on prod/overflow after edge k+2, i.e. 3 clock edges. Throughput is one result per cycle. Back-to-back operand changes every cycle must never mix results.
- 4x4 block: four 2x2 cells plus adders, same structure as the 8x8 level, purely combinational inside stage 2.
- 2x2 cell: bit ANDs plus half adders, 4-bit result.
- Arithmetic is unsigned. The maximum result is 255*255=65025, which fits in 16 bits, so no truncation occurs.
- overflow equals the OR-reduction of prod[15:8] and is registered in the same stage as prod, so the two are always coherent.
- Reset mid-stream: all in-flight results are discarded. After release, outputs remain 0 until the first post-release sample reaches stage 3. Sampled zeros then produce 0 with overflow=0.
- No X propagation: the output is defined whenever rst_n has been asserted at least once.

Test Plan:
- Reset: hold rst_n=0 with a=255, b=255 → prod=0 and overflow=0 throughout. Release rst_n → 65025 appears exactly 3 edges after the first sampling edge.
- Streaming sequence, one operand pair per cycle, each result checked 3 edges after its inputs:
  - 15*3 → 45, ovf=0
  - 25*10 → 250, ovf=0
  - 50*50 → 2500, ovf=1
  - 100*200 → 20000, ovf=1
  - 255*255 → 65025, ovf=1
- Edge values:
  - 1*255 → 255, ovf=0
  - 0*255 → 0, ovf=0
  - 128*128 → 16384, ovf=1
  - 16*16 → 256, ovf=1 (boundary)
  - 15*17 → 255, ovf=0 (boundary)
- Reset asserted mid-stream while 3 distinct products are in flight → prod goes to 0 immediately (asynchronous), and none of the in-flight results appear after release.
- Exhaustive: all 65536 (a,b) pairs streamed back-to-back → every prod equals a*b and overflow equals (a*b>255), at latency 3 with no skipped or duplicated results.
